// File: rtl/reset_pkg.sv
// Shared types and helpers for the reset sequencer slice.
package reset_pkg;

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    RELEASE,
    RUN
  } rseq_state_t;

  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_EXT = 1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/reset_sync3.sv
// 3-bit two-flop synchronizer; both stages preset to 1 by the block reset.
module reset_sync3 (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);

  logic [2:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Votes TMR reset requests, stretches them, and releases domain resets in index order.
// Optional TMR disagreement monitor: define RESET_SEQ_MISMATCH_EN.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned NDOM     = 4,
  parameter int unsigned MIN_HOLD = 16,
  parameter int unsigned STEP     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      rst_req,
  input  logic [2:0]      por_status,
  input  logic            sw_rst,
  input  logic            cause_clr,
  output logic [NDOM-1:0] domain_rst,
  output logic            seq_done,
  output logic [1:0]      rst_cause,
  output logic            mismatch
);

  localparam int unsigned CNT_MAX = (MIN_HOLD > STEP) ? MIN_HOLD : STEP;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned IW      = (NDOM > 1) ? $clog2(NDOM) : 1;

  logic [2:0] reqSync;
  logic [2:0] porSync;
  logic       reqV;
  logic       porV;
  logic       anyReq;

  rseq_state_t     state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic [IW-1:0]   idx, idxNext;
  logic [NDOM-1:0] domRst, domRstNext;
  logic            seqDone, seqDoneNext;
  logic [1:0]      cause, causeNext;

  reset_sync3 uReqSync (
    .clk (clk),
    .rst (rst),
    .d   (rst_req),
    .q   (reqSync)
  );

  reset_sync3 uPorSync (
    .clk (clk),
    .rst (rst),
    .d   (por_status),
    .q   (porSync)
  );

  assign reqV   = maj3(reqSync);
  assign porV   = maj3(porSync);
  assign anyReq = reqV | porV | sw_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      domRst  <= '1;
      seqDone <= 1'b0;
      cause   <= 2'b01;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      idx     <= idxNext;
      domRst  <= domRstNext;
      seqDone <= seqDoneNext;
      cause   <= causeNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    idxNext     = idx;
    domRstNext  = domRst;
    seqDoneNext = seqDone;

    if (anyReq) begin
      // Assertion is immediate from any state; the counter is preloaded for the stretch.
      stateNext   = HOLD;
      cntNext     = CW'(MIN_HOLD - 1);
      idxNext     = '0;
      domRstNext  = '1;
      seqDoneNext = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          stateNext = STRETCH;
          cntNext   = CW'(MIN_HOLD - 1);
        end
        STRETCH: begin
          // The HOLD exit edge is the first quiet cycle, so the stretch ends at a count of 1.
          if (cnt <= CW'(1)) begin
            idxNext       = '0;
            domRstNext    = '1;
            domRstNext[0] = 1'b0;
            if (NDOM == 1) begin
              stateNext   = RUN;
              seqDoneNext = 1'b1;
            end else begin
              stateNext = RELEASE;
              cntNext   = CW'(STEP - 1);
            end
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            if (idx < IW'(NDOM - 1)) begin
              idxNext = idx + IW'(1);
            end
            for (int unsigned k = 0; k < NDOM; k++) begin
              if (k <= 32'(idxNext)) begin
                domRstNext[k] = 1'b0;
              end
            end
            if (idxNext == IW'(NDOM - 1)) begin
              stateNext   = RUN;
              seqDoneNext = 1'b1;
            end else begin
              cntNext = CW'(STEP - 1);
            end
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
        RUN: begin
          domRstNext  = '0;
          seqDoneNext = 1'b1;
        end
        default: begin
          stateNext  = HOLD;
          domRstNext = '1;
        end
      endcase
    end
  end

  // A cause that fires in the same cycle as cause_clr survives the clear.
  always_comb begin
    causeNext = cause_clr ? 2'b00 : cause;
    if (porV) begin
      causeNext[CAUSE_POR] = 1'b1;
    end
    if (reqV | sw_rst) begin
      causeNext[CAUSE_EXT] = 1'b1;
    end
  end

  assign domain_rst = domRst;
  assign seq_done   = seqDone;
  assign rst_cause  = cause;

`ifdef RESET_SEQ_MISMATCH_EN
  logic disagree;
  logic disPrev;
  logic mismatchQ;

  assign disagree = ((reqSync != 3'b000) && (reqSync != 3'b111)) ||
                    ((porSync != 3'b000) && (porSync != 3'b111));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disPrev   <= 1'b0;
      mismatchQ <= 1'b0;
    end else begin
      disPrev <= disagree;
      if (disagree && disPrev) begin
        mismatchQ <= 1'b1;
      end else if (cause_clr) begin
        mismatchQ <= 1'b0;
      end
    end
  end

  assign mismatch = mismatchQ;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random traffic
// against a time-since-last-request model. Honours RESET_SEQ_MISMATCH_EN.
module tb_reset_sequencer;

  localparam int NDOM     = 4;
  localparam int MIN_HOLD = 16;
  localparam int STEP     = 8;
  localparam int SEQ_END  = MIN_HOLD + (NDOM - 1) * STEP;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      rst_req = '0;
  logic [2:0]      por_status = '0;
  logic            sw_rst = 1'b0;
  logic            cause_clr = 1'b0;
  logic [NDOM-1:0] domain_rst;
  logic            seq_done;
  logic [1:0]      rst_cause;
  logic            mismatch;

  reset_sequencer #(
    .NDOM     (NDOM),
    .MIN_HOLD (MIN_HOLD),
    .STEP     (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rst_req    (rst_req),
    .por_status (por_status),
    .sw_rst     (sw_rst),
    .cause_clr  (cause_clr),
    .domain_rst (domain_rst),
    .seq_done   (seq_done),
    .rst_cause  (rst_cause),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  int errCnt = 0;
  int chkCnt = 0;

  // Reference state: edges since reset release, last edge that saw a request.
  int         n;
  int         lastReq;
  logic [1:0] mCause;
  logic       mMis;
  logic       mDisPrev;
  logic [2:0] rD1, rD2, pD1, pD2;

  logic [2:0] twoLeg [4] = '{3'b011, 3'b101, 3'b110, 3'b111};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic vote(input logic [2:0] v);
    return $countones(v) >= 2;
  endfunction

  function automatic logic [NDOM-1:0] expDom(input int el);
    logic [NDOM-1:0] v;
    v = {NDOM{1'b1}};
    for (int k = 0; k < NDOM; k++) begin
      if (el >= MIN_HOLD + k * STEP) v[k] = 1'b0;
    end
    return v;
  endfunction

  task automatic modelReset();
    n        = 0;
    lastReq  = 0;
    mCause   = 2'b01;
    mMis     = 1'b0;
    mDisPrev = 1'b0;
    rD1 = '1; rD2 = '1; pD1 = '1; pD2 = '1;
  endtask

  task automatic tick();
    logic [2:0] rs, ps;
    logic       anyReq, dis;
    @(posedge clk);
    n++;
    rs  = rD2;  ps  = pD2;
    rD2 = rD1;  rD1 = rst_req;
    pD2 = pD1;  pD1 = por_status;
    anyReq = vote(rs) | vote(ps) | sw_rst;
    if (anyReq) lastReq = n;
    if (cause_clr) mCause = 2'b00;
    if (vote(ps)) mCause[0] = 1'b1;
    if (vote(rs) || sw_rst) mCause[1] = 1'b1;
    dis = !(rs == 3'b000 || rs == 3'b111) || !(ps == 3'b000 || ps == 3'b111);
    if (cause_clr) mMis = 1'b0;
    if (dis && mDisPrev) mMis = 1'b1;
    mDisPrev = dis;
    #1;
    checkVal("domain_rst", domain_rst, expDom(n - lastReq));
    checkVal("seq_done", seq_done, ((n - lastReq) >= SEQ_END));
    checkVal("rst_cause", rst_cause, mCause);
`ifdef RESET_SEQ_MISMATCH_EN
    checkVal("mismatch", mismatch, mMis);
`else
    checkVal("mismatch", mismatch, 1'b0);
`endif
  endtask

  task automatic resetChecks(input string tag);
    checkVal({tag, "_dom"}, domain_rst, {NDOM{1'b1}});
    checkVal({tag, "_done"}, seq_done, 1'b0);
    checkVal({tag, "_cause"}, rst_cause, 2'b01);
    checkVal({tag, "_mis"}, mismatch, 1'b0);
  endtask

  // Called just after a tick; asserts rst between clock edges and checks before any edge.
  task automatic asyncReset(input string tag);
    #2;
    rst        = 1'b1;
    rst_req    = '0;
    por_status = '0;
    cause_clr  = 1'b0;
    #1;
    resetChecks(tag);
    sw_rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      resetChecks({tag, "_hold"});
    end
    sw_rst = 1'b0;
    rst    = 1'b0;
    modelReset();
  endtask

  task automatic pulseReq(input logic [2:0] v, input int len);
    rst_req = v;
    repeat (len) tick();
    rst_req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int reqLeft;
    int porLeft;
    int r;
    bit reached;

    modelReset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetChecks("reset");
    rst = 1'b0;
    modelReset();

    // Power-up release timing
    for (int i = 0; i < 45; i++) begin
      tick();
      if (n == 17) checkVal("t1_e17", domain_rst, 4'b1111);
      if (n == 18) checkVal("t1_bit0", domain_rst, 4'b1110);
      if (n == 26) checkVal("t1_bit1", domain_rst, 4'b1100);
      if (n == 34) checkVal("t1_bit2", domain_rst, 4'b1000);
      if (n == 41) checkVal("t1_notdone", seq_done, 1'b0);
      if (n == 42) begin
        checkVal("t1_bit3", domain_rst, 4'b0000);
        checkVal("t1_done", seq_done, 1'b1);
      end
    end

    // Single-leg request is outvoted
    pulseReq(3'b010, 50);
    checkVal("t2_dom", domain_rst, 4'b0000);
    repeat (5) tick();

    // Two-leg pulse from RUN
    rst_req = 3'b011;
    tick(); tick();
    checkVal("t3_dom_pre", domain_rst, 4'b0000);
    tick();
    checkVal("t3_dom", domain_rst, 4'b1111);
    checkVal("t3_done", seq_done, 1'b0);
    rst_req = '0;
    repeat (60) tick();

    // Re-request after bit1 released
    pulseReq(3'b011, 3);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      tick();
      if ((n - lastReq) == MIN_HOLD + STEP) reached = 1'b1;
    end
    checkVal("t4_reach", reached, 1'b1);
    checkVal("t4_mid", domain_rst, 4'b1100);
    pulseReq(3'b111, 1);
    tick(); tick();
    checkVal("t4_dom", domain_rst, 4'b1111);
    repeat (60) tick();

    // Cause handling
    cause_clr = 1'b1; tick(); cause_clr = 1'b0;
    checkVal("t5_clr0", rst_cause, 2'b00);
    por_status = 3'b111; tick(); por_status = '0;
    repeat (3) tick();
    checkVal("t5_por", rst_cause, 2'b01);
    sw_rst = 1'b1; tick(); sw_rst = 1'b0;
    checkVal("t5_sw", rst_cause, 2'b11);
    cause_clr = 1'b1; tick(); cause_clr = 1'b0;
    checkVal("t5_clr", rst_cause, 2'b00);
    cause_clr = 1'b1; sw_rst = 1'b1; tick(); cause_clr = 1'b0; sw_rst = 1'b0;
    checkVal("t5_clrsw", rst_cause, 2'b10);
    repeat (50) tick();

    // Async rst mid-STRETCH, then mid-RUN
    pulseReq(3'b011, 3);
    repeat (6) tick();
    asyncReset("t6_stretch");
    repeat (45) tick();
    checkVal("t6_run", seq_done, 1'b1);
    asyncReset("t6_run");

    // Random traffic
    reqLeft = 0;
    porLeft = 0;
    for (int c = 0; c < 3000; c++) begin
      sw_rst    = 1'b0;
      cause_clr = 1'b0;
      if (reqLeft > 0) begin
        reqLeft--;
        if (reqLeft == 0) rst_req = '0;
      end
      if (porLeft > 0) begin
        porLeft--;
        if (porLeft == 0) por_status = '0;
      end
      r = $urandom_range(0, 299);
      if (r < 2 && reqLeft == 0) begin
        rst_req = twoLeg[$urandom_range(0, 3)];
        reqLeft = $urandom_range(1, 5);
      end else if (r < 4 && reqLeft == 0) begin
        rst_req = 3'b001 << $urandom_range(0, 2);
        reqLeft = $urandom_range(5, 40);
      end else if (r == 4 && porLeft == 0) begin
        por_status = twoLeg[$urandom_range(0, 3)];
        porLeft    = $urandom_range(1, 4);
      end else if (r == 5 && porLeft == 0) begin
        por_status = 3'b001 << $urandom_range(0, 2);
        porLeft    = $urandom_range(2, 20);
      end else if (r == 6) begin
        sw_rst = 1'b1;
      end else if (r < 10) begin
        cause_clr = 1'b1;
      end else if (r == 10) begin
        cause_clr = 1'b1;
        sw_rst    = 1'b1;
      end
      tick();
      if (r == 11) begin
        asyncReset("rnd_async");
        reqLeft = 0;
        porLeft = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
